// File: rtl/dualport_fifo_ctrl.sv
// dualport_fifo_ctrl: stream FIFO controller in front of an external dual-port RAM.
// Write side (port A) takes words from the upstream stream. The read side (port B)
// fetches into a 2-entry output buffer. That buffer hides the RAM's 1-cycle registered
// read latency, so the FIFO can sustain one word per cycle.
// Optional feature: define FIFO_LEVEL_EN to add registered LEVEL and ALMOST_FULL outputs.
module dualport_fifo_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] S_TDATA,
  input  logic                  S_TVALID,
  output logic                  S_TREADY,
  output logic [DATA_WIDTH-1:0] M_TDATA,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic [ADDR_WIDTH-1:0] RAM_W_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_W_DATA,
  output logic                  RAM_W_EN,
  output logic [ADDR_WIDTH-1:0] RAM_R_ADDR,
  input  logic [DATA_WIDTH-1:0] RAM_R_DATA,
  output logic                  FULL,
  output logic                  EMPTY
`ifdef FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] LEVEL,
  output logic                  ALMOST_FULL
`endif
);

  // RAM_DEPTH marks the full condition. It has a 1 in the wrap bit and zeros below it.
  localparam logic [ADDR_WIDTH:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Registered state
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  inflight;
  logic [1:0]            ob_cnt;
  logic [DATA_WIDTH-1:0] ob_head;
  logic [DATA_WIDTH-1:0] ob_tail;

  // Next-state values
  logic [ADDR_WIDTH:0]   wr_ptr_nxt;
  logic [ADDR_WIDTH:0]   rd_ptr_nxt;
  logic                  inflight_nxt;
  logic [1:0]            ob_cnt_nxt;
  logic [DATA_WIDTH-1:0] ob_head_nxt;
  logic [DATA_WIDTH-1:0] ob_tail_nxt;

  // Handshake and control terms
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  ram_full;
  logic                  accept;
  logic                  pop;
  logic                  fetch;
  logic [2:0]            ob_claim;

  // Compute occupancy and handshakes from the registered pointers and the buffer state.
  always_comb begin
    ram_cnt  = wr_ptr - rd_ptr;
    ram_full = (ram_cnt == RAM_DEPTH);
    accept   = S_TVALID && !ram_full && !ARESET;
    pop      = (ob_cnt != 2'd0) && M_TREADY;
    // ob_claim counts buffer slots that are taken or promised once this cycle's pop is done.
    ob_claim = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
    fetch    = (ram_cnt != '0) && (ob_claim < 3'd2);
  end

  // Drive the stream and RAM port outputs.
  always_comb begin
    S_TREADY   = !ram_full && !ARESET;
    RAM_W_EN   = accept;
    RAM_W_ADDR = wr_ptr[ADDR_WIDTH-1:0];
    RAM_W_DATA = S_TDATA;
    RAM_R_ADDR = rd_ptr[ADDR_WIDTH-1:0];
    M_TDATA    = ob_head;
    M_TVALID   = (ob_cnt != 2'd0);
    FULL       = ram_full;
    EMPTY      = (ram_cnt == '0) && !inflight && (ob_cnt == 2'd0);
  end

  // Compute the next pointer values and the next in-flight flag.
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    inflight_nxt = 1'b0;
    if (accept) begin
      wr_ptr_nxt = wr_ptr + 1'b1;
    end
    if (fetch) begin
      rd_ptr_nxt   = rd_ptr + 1'b1;
      inflight_nxt = 1'b1;
    end
  end

  // Compute the next output buffer state: capture the fetched word, pop the head, or both.
  always_comb begin
    ob_cnt_nxt  = ob_cnt;
    ob_head_nxt = ob_head;
    ob_tail_nxt = ob_tail;
    case ({inflight, pop})
      2'b01: begin
        ob_head_nxt = ob_tail;
        ob_cnt_nxt  = ob_cnt - 2'd1;
      end
      2'b10: begin
        if (ob_cnt == 2'd0) begin
          ob_head_nxt = RAM_R_DATA;
        end else begin
          ob_tail_nxt = RAM_R_DATA;
        end
        ob_cnt_nxt = ob_cnt + 2'd1;
      end
      2'b11: begin
        // A push and a pop together: the count stays the same and the buffer shifts by one.
        if (ob_cnt == 2'd1) begin
          ob_head_nxt = RAM_R_DATA;
        end else begin
          ob_head_nxt = ob_tail;
          ob_tail_nxt = RAM_R_DATA;
        end
      end
      default: begin
        ob_cnt_nxt = ob_cnt;
      end
    endcase
  end

  // Register the pointers, the in-flight flag and the buffer occupancy. Reset discards everything stored.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      inflight <= inflight_nxt;
      ob_cnt   <= ob_cnt_nxt;
    end
  end

  // Register the output buffer data.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ob_head <= '0;
      ob_tail <= '0;
    end else begin
      ob_head <= ob_head_nxt;
      ob_tail <= ob_tail_nxt;
    end
  end

`ifdef FIFO_LEVEL_EN
  localparam logic [ADDR_WIDTH+1:0] AFULL_LVL = AFULL_THRESH[ADDR_WIDTH+1:0];

  logic [ADDR_WIDTH+1:0] ram_cnt_nxt;
  logic [ADDR_WIDTH+1:0] level_nxt;

  // Build LEVEL and ALMOST_FULL from next-state values, so each register matches the state it reports.
  always_comb begin
    ram_cnt_nxt = {1'b0, wr_ptr_nxt - rd_ptr_nxt};
    level_nxt   = ram_cnt_nxt + {{(ADDR_WIDTH+1){1'b0}}, inflight_nxt}
                + {{ADDR_WIDTH{1'b0}}, ob_cnt_nxt};
  end

  // Register the level outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      LEVEL       <= '0;
      ALMOST_FULL <= 1'b0;
    end else begin
      LEVEL       <= level_nxt;
      ALMOST_FULL <= (ram_cnt_nxt >= AFULL_LVL);
    end
  end
`endif

endmodule
